// File: rtl/id_scoreboard_ctrl.sv
// Register scoreboard for the decode stage: tracks pending register writes, raises
// stall on RAW/WAW hazards and latches a sticky error if a stall outlasts STALL_LIMIT.
module id_scoreboard_ctrl #(
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [4:0]  id_dest,
  input  logic        id_reg_write,
  input  logic        wb_valid,
  input  logic [4:0]  wb_dest,
  input  logic        flush,
  output logic        stall,
  output logic        issue,
  output logic [31:0] busy_mask,
  output logic [5:0]  pending_cnt,
  output logic        err
);

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  typedef enum logic [1:0] {RUN, STALL, ERR} state_e;

  state_e      state_q, state_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic [31:0] busy_q, busy_d;
  logic [5:0]  pending_q, pending_d;
  logic        err_q, err_d;
  logic        hazard;

  // Hazards look only at the registered mask; a writeback in the same cycle
  // does not release the stall until the following cycle.
  assign hazard = id_valid & ((id_rs_used   & busy_q[id_rs]) |
                              (id_rt_used   & busy_q[id_rt]) |
                              (id_reg_write & busy_q[id_dest]));

  assign stall = (hazard & ~flush) | (state_q == ERR);
  assign issue = id_valid & ~hazard & ~flush & (state_q != ERR);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    busy_d      = busy_q;
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q;
    pending_d   = '0;

    if (wb_valid && wb_dest != 5'd0) busy_d[wb_dest] = 1'b0;
    // Set is applied after clear so that a same-cycle set wins.
    if (issue && id_reg_write && id_dest != 5'd0) busy_d[id_dest] = 1'b1;
    busy_d[0] = 1'b0;

    for (int i = 0; i < 32; i++) pending_d = pending_d + 6'(busy_d[i]);

    unique case (state_q)
      RUN: begin
        if (hazard && !flush) begin
          state_d     = STALL;
          stall_cnt_d = 8'd1;
        end else begin
          stall_cnt_d = 8'd0;
        end
      end
      STALL: begin
        if (flush || !hazard) begin
          state_d     = RUN;
          stall_cnt_d = 8'd0;
        end else if (stall_cnt_q == LIMIT) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + 8'd1;
        end
      end
      ERR: begin
        state_d = ERR;
        err_d   = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      busy_q      <= '0;
      pending_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      busy_q      <= busy_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
    end
  end

  assign busy_mask   = busy_q;
  assign pending_cnt = pending_q;
  assign err         = err_q;

endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// Directed bench for id_scoreboard_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_id_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_used, id_rt_used, id_reg_write, wb_valid, flush;
  logic [4:0]  id_rs, id_rt, id_dest, wb_dest;
  logic        stall, issue, err;
  logic [31:0] busy_mask;
  logic [5:0]  pending_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [40:0] vec;   // {stall, issue, busy_mask, pending_cnt, err}
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  id_scoreboard_ctrl #(.STALL_LIMIT(15)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_dest(id_dest), .id_reg_write(id_reg_write),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
    .stall(stall), .issue(issue), .busy_mask(busy_mask),
    .pending_cnt(pending_cnt), .err(err)
  );

  task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got stall=%b issue=%b busy=%h cnt=%0d err=%b, want stall=%b issue=%b busy=%h cnt=%0d err=%b",
               name, act[40], act[39], act[38:7], act[6:1], act[0],
               exp[40], exp[39], exp[38:7], exp[6:1], exp[0]);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare it
  // whenever an expectation is outstanding.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, {stall, issue, busy_mask, pending_cnt, err}, e.vec);
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_dest = 0; id_reg_write = 0; wb_valid = 0; wb_dest = 0; flush = 0;
  endtask

  // Push the expectation for the current input set, then advance one cycle.
  task automatic cyc(input string name, input logic s, input logic i,
                     input logic [31:0] busy, input logic e);
    exp_t x;
    x.name = name;
    x.vec  = {s, i, busy, 6'($countones(busy)), e};
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;

    cyc("reset_idle", 0, 0, 32'h0, 0);
    id_valid = 1; id_reg_write = 1; id_dest = 5'd9;
    cyc("reset_comb_issue", 0, 1, 32'h0, 0);
    rst = 1'b1; idle();
    cyc("reset_release", 0, 0, 32'h0, 0);

    // RAW on r5 released by writeback
    id_valid = 1; id_reg_write = 1; id_dest = 5'd5;
    cyc("issue_r5", 0, 1, 32'h0, 0);
    idle(); id_valid = 1; id_rs = 5'd5; id_rs_used = 1; wb_valid = 1; wb_dest = 5'd5;
    cyc("raw_r5_stall", 1, 0, 32'h20, 0);
    wb_valid = 0; wb_dest = 0;
    cyc("raw_r5_release", 0, 1, 32'h0, 0);

    // r0 is never tracked
    idle(); id_valid = 1; id_reg_write = 1; id_dest = 5'd0;
    cyc("issue_r0", 0, 1, 32'h0, 0);
    idle(); id_valid = 1; id_rs = 5'd0; id_rs_used = 1;
    cyc("read_r0", 0, 1, 32'h0, 0);

    // Same-cycle set and clear of r7: set wins
    idle(); id_valid = 1; id_reg_write = 1; id_dest = 5'd7; wb_valid = 1; wb_dest = 5'd7;
    cyc("set_wins_r7", 0, 1, 32'h0, 0);
    idle();
    cyc("r7_busy", 0, 0, 32'h80, 0);
    wb_valid = 1; wb_dest = 5'd3;
    cyc("wb_nonbusy", 0, 0, 32'h80, 0);
    idle();
    cyc("wb_nonbusy_after", 0, 0, 32'h80, 0);

    // Flush on a hazard cycle
    id_valid = 1; id_rt = 5'd7; id_rt_used = 1; id_reg_write = 1; id_dest = 5'd12; flush = 1;
    cyc("flush_hazard", 0, 0, 32'h80, 0);
    idle();
    cyc("flush_no_set", 0, 0, 32'h80, 0);

    // WAW on r7, then flush from STALL back to RUN
    id_valid = 1; id_reg_write = 1; id_dest = 5'd7;
    cyc("waw_r7", 1, 0, 32'h80, 0);
    flush = 1;
    cyc("stall_flush", 0, 0, 32'h80, 0);
    idle(); wb_valid = 1; wb_dest = 5'd7;
    cyc("wb_r7", 0, 0, 32'h80, 0);
    idle();
    cyc("r7_cleared", 0, 0, 32'h0, 0);

    // Three writers pending
    id_valid = 1; id_reg_write = 1; id_dest = 5'd1;
    cyc("issue_r1", 0, 1, 32'h0, 0);
    id_dest = 5'd2;
    cyc("issue_r2", 0, 1, 32'h2, 0);
    id_dest = 5'd3;
    cyc("issue_r3", 0, 1, 32'h6, 0);
    idle();
    cyc("pending_3", 0, 0, 32'hE, 0);

    // Hold a RAW hazard on r1 for 16 cycles: err rises after the 16th edge
    id_valid = 1; id_rs = 5'd1; id_rs_used = 1;
    for (int k = 0; k < 16; k++) cyc("stall_hold", 1, 0, 32'hE, 0);
    idle(); id_valid = 1; id_rs = 5'd4; id_rs_used = 1; id_reg_write = 1; id_dest = 5'd8;
    wb_valid = 1; wb_dest = 5'd2;
    cyc("err_entered", 1, 0, 32'hE, 1);
    wb_valid = 0; wb_dest = 0;
    cyc("err_wb_no_set", 1, 0, 32'hA, 1);

    // Reset out of ERR
    idle(); rst = 1'b0; wb_valid = 1; wb_dest = 5'd1;
    cyc("err_reset_edge", 1, 0, 32'hA, 1);
    idle(); rst = 1'b1; id_valid = 1;
    cyc("after_err_reset", 0, 1, 32'h0, 0);
    idle();
    cyc("final_idle", 0, 0, 32'h0, 0);

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, want finish before 20000");
    $fatal(1);
  end

endmodule
